// File: rtl/alu_decoder.sv
// ALU control decoder: maps (alu_op, s, cmd) to registered ALU/flag/shifter controls.
// Optional macro ALU_DEC_ILLEGAL_EN adds a registered `illegal` output for BIC/MVN.
module alu_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_op,
  input  logic       s,
  input  logic [3:0] cmd,
  output logic [2:0] alu_ctl,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       shift,
  output logic       swap
`ifdef ALU_DEC_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

  logic [2:0] alu_ctl_s;
  logic [1:0] flag_sel_s;
  logic       flag_force_s;
  logic [1:0] flag_w_s;
  logic       no_write_s;
  logic       shift_s;
  logic       swap_s;
  logic       illegal_s;

  logic [2:0] alu_ctl_r;
  logic [1:0] flag_w_r;
  logic       no_write_r;
  logic       shift_r;
  logic       swap_r;
  logic       illegal_r;

  // Next-state decode; compare-class ops write flags whether or not S is set
  always_comb begin
    alu_ctl_s    = 3'b000;
    flag_sel_s   = 2'b00;
    flag_force_s = 1'b0;
    no_write_s   = 1'b0;
    shift_s      = 1'b0;
    swap_s       = 1'b0;
    illegal_s    = 1'b0;
    if (alu_op == 1'b1) begin
      case (cmd)
        4'b0100: begin alu_ctl_s = 3'b000; flag_sel_s = 2'b11; end
        4'b0010: begin alu_ctl_s = 3'b001; flag_sel_s = 2'b11; end
        4'b0000: begin alu_ctl_s = 3'b010; flag_sel_s = 2'b10; end
        4'b1100: begin alu_ctl_s = 3'b011; flag_sel_s = 2'b10; end
        4'b0001: begin alu_ctl_s = 3'b110; flag_sel_s = 2'b10; end
        4'b0101: begin alu_ctl_s = 3'b100; flag_sel_s = 2'b11; end
        4'b0110: begin alu_ctl_s = 3'b101; flag_sel_s = 2'b11; end
        4'b0011: begin alu_ctl_s = 3'b001; flag_sel_s = 2'b11; swap_s = 1'b1; end
        4'b0111: begin alu_ctl_s = 3'b101; flag_sel_s = 2'b11; swap_s = 1'b1; end
        4'b1010: begin alu_ctl_s = 3'b001; flag_sel_s = 2'b11; flag_force_s = 1'b1; no_write_s = 1'b1; end
        4'b1011: begin alu_ctl_s = 3'b000; flag_sel_s = 2'b11; flag_force_s = 1'b1; no_write_s = 1'b1; end
        4'b1000: begin alu_ctl_s = 3'b010; flag_sel_s = 2'b10; flag_force_s = 1'b1; no_write_s = 1'b1; end
        4'b1001: begin alu_ctl_s = 3'b110; flag_sel_s = 2'b10; flag_force_s = 1'b1; no_write_s = 1'b1; end
        4'b1101: begin alu_ctl_s = 3'b000; flag_sel_s = 2'b10; shift_s = 1'b1; end
        4'b1110: begin illegal_s = 1'b1; end
        4'b1111: begin illegal_s = 1'b1; end
        default: begin alu_ctl_s = 3'b000; end
      endcase
    end else begin
      alu_ctl_s = 3'b000;
    end
    if ((flag_force_s == 1'b1) || (s == 1'b1)) begin
      flag_w_s = flag_sel_s;
    end else begin
      flag_w_s = 2'b00;
    end
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctl_r  <= 3'b000;
      flag_w_r   <= 2'b00;
      no_write_r <= 1'b0;
      shift_r    <= 1'b0;
      swap_r     <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      alu_ctl_r  <= alu_ctl_s;
      flag_w_r   <= flag_w_s;
      no_write_r <= no_write_s;
      shift_r    <= shift_s;
      swap_r     <= swap_s;
      illegal_r  <= illegal_s;
    end
  end

  assign alu_ctl  = alu_ctl_r;
  assign flag_w   = flag_w_r;
  assign no_write = no_write_r;
  assign shift    = shift_r;
  assign swap     = swap_r;

`ifdef ALU_DEC_ILLEGAL_EN
  assign illegal = illegal_r;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_r;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: expectations queued at drive time, popped one edge later.
module tb_alu_decoder;

  logic       clk;
  logic       reset;
  logic       alu_op;
  logic       s;
  logic [3:0] cmd;
  logic [2:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       shift;
  logic       swap;
  logic       illegal;

  int n_compared = 0;
  int n_mismatch = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;

  alu_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .s        (s),
    .cmd      (cmd),
    .alu_ctl  (alu_ctl),
    .flag_w   (flag_w),
    .no_write (no_write),
    .shift    (shift),
    .swap     (swap)
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    .illegal  (illegal)
`endif
  );

`ifndef ALU_DEC_ILLEGAL_EN
  assign illegal = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {illegal, alu_ctl[2:0], flag_w[1:0], no_write, shift, swap}
  function automatic logic [8:0] observed();
    return {illegal, alu_ctl, flag_w, no_write, shift, swap};
  endfunction

  // Reference model written straight from the opcode table
  function automatic logic [8:0] model(input logic ao, input logic sb, input logic [3:0] c);
    logic [2:0] a;
    logic [1:0] f;
    logic nw, sh, sw, ill;
    a = 3'b000; f = 2'b00; nw = 1'b0; sh = 1'b0; sw = 1'b0; ill = 1'b0;
    if (ao) begin
      case (c)
        4'h4: begin a = 3'd0; f = sb ? 2'b11 : 2'b00; end
        4'h2: begin a = 3'd1; f = sb ? 2'b11 : 2'b00; end
        4'h0: begin a = 3'd2; f = sb ? 2'b10 : 2'b00; end
        4'hC: begin a = 3'd3; f = sb ? 2'b10 : 2'b00; end
        4'h1: begin a = 3'd6; f = sb ? 2'b10 : 2'b00; end
        4'h5: begin a = 3'd4; f = sb ? 2'b11 : 2'b00; end
        4'h6: begin a = 3'd5; f = sb ? 2'b11 : 2'b00; end
        4'h3: begin a = 3'd1; sw = 1'b1; f = sb ? 2'b11 : 2'b00; end
        4'h7: begin a = 3'd5; sw = 1'b1; f = sb ? 2'b11 : 2'b00; end
        4'hA: begin a = 3'd1; nw = 1'b1; f = 2'b11; end
        4'hB: begin a = 3'd0; nw = 1'b1; f = 2'b11; end
        4'h8: begin a = 3'd2; nw = 1'b1; f = 2'b10; end
        4'h9: begin a = 3'd6; nw = 1'b1; f = 2'b10; end
        4'hD: begin sh = 1'b1; f = sb ? 2'b10 : 2'b00; end
        default: begin
`ifdef ALU_DEC_ILLEGAL_EN
          ill = 1'b1;
`endif
        end
      endcase
    end
    return {ill, a, f, nw, sh, sw};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got {ill,ctl,fw,nw,sh,sw}=%b required %b", tag, got, exp);
    end
  endtask

  // Drive at negedge, queue expectation, compare #1 after the capturing edge
  task automatic apply(input logic ao, input logic sb, input logic [3:0] c, input string tag);
    @(negedge clk);
    alu_op = ao; s = sb; cmd = c;
    exp_q.push_back(model(ao, sb, c));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatch++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, observed(), last_exp);
    end
  endtask

  initial begin
    reset = 1'b1; alu_op = 1'b1; s = 1'b1; cmd = 4'b0100;
    #3;
    check("rst_init", observed(), 9'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(9'b0_000_11_000);
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check("rst_release_add", observed(), last_exp);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", observed(), 9'd0);
    @(posedge clk);
    #1;
    check("rst_hold", observed(), 9'd0);
    @(negedge clk);
    reset = 1'b0;

    apply(1'b0, 1'b1, 4'b0100, "nondp_add_s1");
    check("nondp_const", observed(), 9'd0);

    // Full sweep of cmd x S for data-processing
    for (int i = 0; i < 32; i++) begin
      apply(1'b1, i[4], i[3:0], $sformatf("dp_cmd%0h_s%0d", i[3:0], i[4]));
    end

    // Mid-cycle input change must not reach outputs
    apply(1'b1, 1'b1, 4'b0100, "mid_add");
    #2;
    cmd = 4'b1010; s = 1'b0;
    #1;
    check("mid_hold", observed(), last_exp);

    apply(1'b0, 1'b0, 4'b1110, "nondp_bic");
    apply(1'b0, 1'b1, 4'b1111, "nondp_mvn");
    apply(1'b1, 1'b0, 4'b1111, "mvn_s0");

    for (int k = 0; k < 24; k++) begin
      logic [5:0] r;
      r = 6'($urandom);
      apply(r[5], r[4], r[3:0], $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- ALU control decoder for the ARM-subset CPU control unit.
- Maps the data-processing `cmd` field and S bit to:
  - ALU operation select
  - flag-write enables
  - register-write suppression
  - shifter select
  - operand-swap control
- Outputs are registered: one-cycle latency from inputs to outputs.
- Sits between the main decoder (which supplies `alu_op`) and the datapath ALU, flag logic and shifter.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_op  input  1  1 = data-processing instruction; 0 = non-DP (memory/branch address add).
- s  input  1  instruction S bit (set flags).
- cmd  input  4  instruction cmd field, bits [24:21].
- alu_ctl  output  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC, 101 SBC, 110 EOR, 111 reserved (never driven).
- flag_w  output  2  bit1 = write N,Z; bit0 = write C,V.
- no_write  output  1  1 = suppress destination register write (compare class).
- shift  output  1  1 = result comes from the shifter (MOV/LSL/LSR/ASR/ROR class).
- swap  output  1  1 = swap ALU operands A/B (reverse subtract).

Behaviour:
- Reset (asynchronous, reset=1): all outputs 0 immediately and held while reset is asserted.
- Normal operation:
  - Combinational decode of (alu_op, s, cmd) is registered on each rising clk.
  - Outputs reflect the inputs sampled at the previous edge.
  - No enable, no stall, no handshake.
- alu_op=0: alu_ctl=000, flag_w=00, no_write=0, shift=0, swap=0, regardless of s and cmd.
- alu_op=1, decode by cmd; "S" means flag_w takes the given value when s=1, else 00:
  - 0100 ADD: alu_ctl 000, S→11.
  - 0010 SUB: alu_ctl 001, S→11.
  - 0000 AND: alu_ctl 010, S→10.
  - 1100 ORR: alu_ctl 011, S→10.
  - 0001 EOR: alu_ctl 110, S→10.
  - 0101 ADC: alu_ctl 100, S→11.
  - 0110 SBC: alu_ctl 101, S→11.
  - 0011 RSB: alu_ctl 001, swap=1, S→11.
  - 0111 RSC: alu_ctl 101, swap=1, S→11.
  - 1010 CMP: alu_ctl 001, no_write=1, flag_w=11 regardless of s.
  - 1011 CMN: alu_ctl 000, no_write=1, flag_w=11 regardless of s.
  - 1000 TST: alu_ctl 010, no_write=1, flag_w=10 regardless of s.
  - 1001 TEQ: alu_ctl 110, no_write=1, flag_w=10 regardless of s.
  - 1101 MOV/shift: shift=1, alu_ctl 000 (unused by datapath), S→10.
  - 1110 BIC, 1111 MVN (unsupported): all outputs 0.
- Any output not listed for a cmd is 0. Outputs never carry X/Z after reset.
- Input change mid-cycle has no effect until the next rising edge.
- Reset asserted mid-stream clears outputs asynchronously. First post-reset edge loads the current decode.

Optional Feature:
- Macro `ALU_DEC_ILLEGAL_EN`.
- Defined:
  - Adds output port `illegal` (1 bit, registered, reset 0).
  - `illegal` = 1 when alu_op=1 and cmd ∈ {1110, 1111}; else 0.
  - All other outputs unchanged.
- Undefined: no `illegal` port; behaviour otherwise identical.

Test Plan:
- Reset:
  - Drive alu_op=1, s=1, cmd=0100, assert reset → all outputs 0 with no clock edge.
  - Release reset; after next edge → alu_ctl 000, flag_w 11.
- Non-DP: alu_op=0, s=1, cmd=0100, one clock → alu_ctl 000, flag_w 00, no_write/shift/swap 0.
- Arithmetic/logic sweep, alu_op=1, each value checked one cycle after apply:
  - ADD/SUB/ADC/SBC with s=0 → flag_w 00; with s=1 → flag_w 11; alu_ctl 000/001/100/101.
  - AND/ORR/EOR with s=1 → flag_w 10; alu_ctl 010/011/110.
- Reverse: RSB (0011) and RSC (0111), s=0 and s=1 → alu_ctl 001/101, swap=1, flag_w 00/11.
- Compare class, s=1:
  - CMP → 001, 11, no_write=1.
  - CMN → 000, 11, no_write=1.
  - TST → 010, 10, no_write=1.
  - TEQ → 110, 10, no_write=1.
  - Repeat with s=0: same flag_w.
- Shift and unsupported:
  - cmd 1101, s=0 → shift=1, flag_w 00; s=1 → flag_w 10, alu_ctl 000.
  - cmd 1110/1111 → all 0; with `ALU_DEC_ILLEGAL_EN`, illegal=1, and illegal=0 when alu_op=0.
